// File: rtl/dso100_overlay_pkg.sv
// Shared types and constants for the DSO100 graticule overlay source.
package dso100_overlay_pkg;

    typedef logic [31:0] argb_t;

    localparam argb_t ARGB_TRANSPARENT     = 32'h0000_0000;
    localparam argb_t DEFAULT_GRID_COLOR   = 32'h8080_8080;
    localparam argb_t DEFAULT_CURSOR_COLOR = 32'hFFFF_FF00;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/dso100_overlay_raster_counter.sv
// Raster position (x, y) plus per-axis division phase counters (dx, dy).
// Division counters wrap at DIV_PX-1 so grid lines need no divide or modulo logic.
module dso100_overlay_raster_counter
    import dso100_overlay_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned DIV_PX   = 50
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   advance,
    output coord_t x,
    output coord_t y,
    output logic   dx_zero,
    output logic   dy_zero,
    output logic   last_pixel
);

    localparam int unsigned DIV_W = (DIV_PX > 1) ? $clog2(DIV_PX) : 1;
    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);
    localparam logic [DIV_W-1:0] D_LAST = DIV_W'(DIV_PX - 1);

    logic [DIV_W-1:0] dx;
    logic [DIV_W-1:0] dy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {x, y, dx, dy} <= '0;
        end else if (clear) begin
            {x, y, dx, dy} <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x  <= '0;
                dx <= '0;
                if (y == Y_LAST) begin
                    y  <= '0;
                    dy <= '0;
                end else begin
                    y  <= y + 1'b1;
                    dy <= (dy == D_LAST) ? '0 : dy + 1'b1;
                end
            end else begin
                x  <= x + 1'b1;
                dx <= (dx == D_LAST) ? '0 : dx + 1'b1;
            end
        end
    end

    assign dx_zero    = (dx == '0);
    assign dy_zero    = (dy == '0);
    assign last_pixel = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/dso100_grid_overlay.sv
// Graticule overlay source: streams grid, border and optional crosshair as ARGB8888.
// Crosshair is compiled in only when DSO100_OVERLAY_CURSOR_EN is defined.
module dso100_grid_overlay
    import dso100_overlay_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = 800,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned DIV_PX       = 50,
    parameter argb_t       GRID_COLOR   = DEFAULT_GRID_COLOR,
    parameter argb_t       CURSOR_COLOR = DEFAULT_CURSOR_COLOR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        OVERLAY_SYNC,
    input  logic        OVERLAY_EN,
    output logic        OVERLAY_VALID,
    output logic [31:0] OVERLAY_DATA,
    input  logic        GRID_EN,
    input  logic [9:0]  CURSOR_X,
    input  logic [9:0]  CURSOR_Y,
    output logic        FRAME_DONE
);

    localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
    localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

    state_t state_q, state_d;
    logic   valid_q, valid_d;
    argb_t  data_q, data_d;
    logic   done_q, done_d;
    logic   grid_en_q;

    coord_t x, y;
    logic   dx_zero, dy_zero, last_pixel;
    logic   load, xfer, cursor_hit, border_hit;
    argb_t  pix_color;

    dso100_overlay_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .DIV_PX   (DIV_PX)
    ) u_raster (
        .clk        (CLK),
        .rst        (RST),
        .clear      (OVERLAY_SYNC),
        .advance    (load),
        .x          (x),
        .y          (y),
        .dx_zero    (dx_zero),
        .dy_zero    (dy_zero),
        .last_pixel (last_pixel)
    );

`ifdef DSO100_OVERLAY_CURSOR_EN
    coord_t cursor_x_q, cursor_y_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cursor_x_q <= '0;
            cursor_y_q <= '0;
        end else if (OVERLAY_SYNC) begin
            cursor_x_q <= CURSOR_X;
            cursor_y_q <= CURSOR_Y;
        end
    end

    // x/y never exceed the active area, so off-screen cursor coordinates cannot match.
    assign cursor_hit = (x == cursor_x_q) || (y == cursor_y_q);
`else
    logic unused_cursor;
    assign unused_cursor = ^{CURSOR_X, CURSOR_Y, CURSOR_COLOR};
    assign cursor_hit    = 1'b0;
`endif

    assign border_hit = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);

    always_comb begin
        pix_color = ARGB_TRANSPARENT;
        if (cursor_hit) begin
            pix_color = CURSOR_COLOR;
        end else if (border_hit) begin
            pix_color = GRID_COLOR;
        end else if (grid_en_q && (dx_zero || dy_zero)) begin
            pix_color = GRID_COLOR;
        end
    end

    assign load = (state_q == RUN) && (!valid_q || OVERLAY_EN) && !OVERLAY_SYNC;
    assign xfer = valid_q && OVERLAY_EN;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (OVERLAY_SYNC) begin
            state_d = RUN;
            valid_d = 1'b0;
            data_d  = ARGB_TRANSPARENT;
        end else begin
            if (load) begin
                valid_d = 1'b1;
                data_d  = pix_color;
                if (last_pixel) begin
                    state_d = DONE;
                end
            end else if (xfer) begin
                valid_d = 1'b0;
            end
            // In DONE the output register can only hold the final pixel of the frame.
            done_d = (state_q == DONE) && xfer;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            data_q    <= ARGB_TRANSPARENT;
            done_q    <= 1'b0;
            grid_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (OVERLAY_SYNC) begin
                grid_en_q <= GRID_EN;
            end
        end
    end

    assign OVERLAY_VALID = valid_q;
    assign OVERLAY_DATA  = data_q;
    assign FRAME_DONE    = done_q;

endmodule
